led_sequencer: RTL and testbench

LED pattern sequencer that consumes the tick enable produced by the rate counter and drives the board LEDs. It sits directly downstream of the counter. Each rising edge of `i_valid` advances the current pattern one step. Push buttons select one of four sequencing modes: rotate-left, rotate-right, flash, ping-pong.

---
 rtl/led_sequencer_pkg.sv | 54 +++++
 rtl/led_sequencer_edge_detect.sv | 37 +++
 rtl/led_sequencer.sv | 174 +++++++++++++++++
 tb/tb_led_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/led_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// led_defs
// Shared definitions for the LED sequencer slice.
//   - mode_t : 2-bit sequencing mode encodings (also the o_mode encoding)
//   - dir_t  : ping-pong travel direction
//   - seed_* : reload patterns for each mode, as functions of the LED count
// Seed functions return a MAX_LEDS-wide word. Callers size the result to
// their own LED count with a cast.
// ---------------------------------------------------------------------------
package led_defs;

    localparam int MAX_LEDS = 32;

    typedef enum logic [1:0] {
        MODE_ROT_L = 2'd0,
        MODE_ROT_R = 2'd1,
        MODE_FLASH = 2'd2,
        MODE_PONG  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // 0...01 : single lit LED at bit 0
    function automatic logic [MAX_LEDS-1:0] seed_rot_l(input int nb);
        logic [MAX_LEDS-1:0] s;
        s = '0;
        s[0] = (nb > 0);
        return s;
    endfunction

    // 10...0 : single lit LED at the top bit
    function automatic logic [MAX_LEDS-1:0] seed_rot_r(input int nb);
        logic [MAX_LEDS-1:0] s;
        s = '0;
        s[nb-1] = 1'b1;
        return s;
    endfunction

    // all ones across the nb low bits
    function automatic logic [MAX_LEDS-1:0] seed_flash(input int nb);
        logic [MAX_LEDS-1:0] s;
        s = '1;
        return s >> (MAX_LEDS - nb);
    endfunction

    // ping-pong starts at bit 0 moving left
    function automatic logic [MAX_LEDS-1:0] seed_pong(input int nb);
        return seed_rot_l(nb);
    endfunction

endpackage

// File: rtl/led_sequencer_edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Per-bit rising-edge detector. The delay register resets to 0, so an input
// already high when reset releases produces one rise in the first cycle.
// Ports:
//   clock   in  1   system clock
//   i_reset in  1   synchronous active-high reset
//   i_sig   in  NB  level inputs
//   o_rise  out NB  combinational rise flags (i_sig & ~registered i_sig)
// ---------------------------------------------------------------------------
module edge_detect #(
    parameter int NB = 1
) (
    input  logic          clock,
    input  logic          i_reset,
    input  logic [NB-1:0] i_sig,
    output logic [NB-1:0] o_rise
);

    logic [NB-1:0] sig_d_reg;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            sig_d_reg <= '0;
        end else begin
            sig_d_reg <= i_sig;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_rise
            assign o_rise[gi] = i_sig[gi] & ~sig_d_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
// Advances an LED pattern once per rising edge of the rate-counter tick and
// lets push buttons pick one of four sequencing modes.
// Ports:
//   clock   in  1        system clock
//   i_reset in  1        synchronous active-high reset
//   i_valid in  1        tick enable (pulse or level; only its rise counts)
//   i_btn   in  NB_BTN   debounced mode buttons [0]=ROT_L [1]=ROT_R
//                        [2]=FLASH [3]=PONG
//   o_led   out NB_LEDS  registered LED pattern
//   o_mode  out 2        current mode (led_defs::mode_t encoding)
//   o_step  out 1        high the cycle o_led shows a tick-advanced value
// NB_LEDS must be in 2..MAX_LEDS; NB_BTN is fixed at 4.
// ---------------------------------------------------------------------------
module led_sequencer
    import led_defs::*;
#(
    parameter int NB_LEDS = 4,
    parameter int NB_BTN  = 4
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_BTN-1:0]  i_btn,
    output logic [NB_LEDS-1:0] o_led,
    output logic [1:0]         o_mode,
    output logic               o_step
);

    localparam logic [NB_LEDS-1:0] SEED_ROT_L = NB_LEDS'(seed_rot_l(NB_LEDS));
    localparam logic [NB_LEDS-1:0] SEED_ROT_R = NB_LEDS'(seed_rot_r(NB_LEDS));
    localparam logic [NB_LEDS-1:0] SEED_FLASH = NB_LEDS'(seed_flash(NB_LEDS));
    localparam logic [NB_LEDS-1:0] SEED_PONG  = NB_LEDS'(seed_pong(NB_LEDS));

    // ---------------------------------------------------------------
    // Edge detection
    // ---------------------------------------------------------------
    logic [0:0]        valid_rise;
    logic [NB_BTN-1:0] btn_rise;
    logic              tick;

    edge_detect #(.NB(1)) u_valid_edge (
        .clock   (clock),
        .i_reset (i_reset),
        .i_sig   (i_valid),
        .o_rise  (valid_rise)
    );

    edge_detect #(.NB(NB_BTN)) u_btn_edge (
        .clock   (clock),
        .i_reset (i_reset),
        .i_sig   (i_btn),
        .o_rise  (btn_rise)
    );

    assign tick = valid_rise[0];

    // ---------------------------------------------------------------
    // Priority encoder: lowest button index wins
    // ---------------------------------------------------------------
    logic  req_valid;
    mode_t req_mode;

    always_comb begin
        req_valid = 1'b1;
        req_mode  = MODE_ROT_L;
        if (btn_rise[0]) begin
            req_mode = MODE_ROT_L;
        end else if (btn_rise[1]) begin
            req_mode = MODE_ROT_R;
        end else if (btn_rise[2]) begin
            req_mode = MODE_FLASH;
        end else if (btn_rise[3]) begin
            req_mode = MODE_PONG;
        end else begin
            req_valid = 1'b0;
        end
    end

    logic [NB_LEDS-1:0] req_seed;

    always_comb begin
        req_seed = SEED_ROT_L;
        case (req_mode)
            MODE_ROT_L: req_seed = SEED_ROT_L;
            MODE_ROT_R: req_seed = SEED_ROT_R;
            MODE_FLASH: req_seed = SEED_FLASH;
            MODE_PONG:  req_seed = SEED_PONG;
            default:    req_seed = SEED_ROT_L;
        endcase
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    mode_t              mode_reg, mode_next;
    dir_t               dir_reg,  dir_next;
    logic [NB_LEDS-1:0] led_reg,  led_next;
    logic               step_reg, step_next;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            mode_reg <= MODE_ROT_L;
            dir_reg  <= DIR_LEFT;
            led_reg  <= SEED_ROT_L;
            step_reg <= 1'b0;
        end else begin
            mode_reg <= mode_next;
            dir_reg  <= dir_next;
            led_reg  <= led_next;
            step_reg <= step_next;
        end
    end

    // ---------------------------------------------------------------
    // Candidate next patterns for a tick in each mode
    // ---------------------------------------------------------------
    logic [NB_LEDS-1:0] rot_l_pat;
    logic [NB_LEDS-1:0] rot_r_pat;
    logic [NB_LEDS-1:0] flash_pat;
    logic [NB_LEDS-1:0] pong_l_pat;
    logic [NB_LEDS-1:0] pong_r_pat;

    assign rot_l_pat  = {led_reg[NB_LEDS-2:0], led_reg[NB_LEDS-1]};
    assign rot_r_pat  = {led_reg[0], led_reg[NB_LEDS-1:1]};
    assign flash_pat  = ~led_reg;
    // Ping-pong shifts without wrap; the direction flip keeps it one-hot.
    assign pong_l_pat = {led_reg[NB_LEDS-2:0], 1'b0};
    assign pong_r_pat = {1'b0, led_reg[NB_LEDS-1:1]};

    // ---------------------------------------------------------------
    // Next-state mux: a request beats a same-cycle tick
    // ---------------------------------------------------------------
    always_comb begin
        mode_next = mode_reg;
        dir_next  = dir_reg;
        led_next  = led_reg;
        step_next = 1'b0;

        if (req_valid) begin
            mode_next = req_mode;
            led_next  = req_seed;
            dir_next  = DIR_LEFT;
        end else if (tick) begin
            step_next = 1'b1;
            case (mode_reg)
                MODE_ROT_L: led_next = rot_l_pat;
                MODE_ROT_R: led_next = rot_r_pat;
                MODE_FLASH: led_next = flash_pat;
                MODE_PONG: begin
                    if (dir_reg == DIR_LEFT) begin
                        led_next = pong_l_pat;
                        // Landing on the top LED turns the bounce around.
                        if (pong_l_pat[NB_LEDS-1]) begin
                            dir_next = DIR_RIGHT;
                        end
                    end else begin
                        led_next = pong_r_pat;
                        if (pong_r_pat[0]) begin
                            dir_next = DIR_LEFT;
                        end
                    end
                end
                default: led_next = led_reg;
            endcase
        end
    end

    assign o_led  = led_reg;
    assign o_mode = mode_reg;
    assign o_step = step_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_sequencer
// Scoreboard bench: stimulus pushes the expected {led, mode, step} for every
// visible output event; the monitor pops and compares whenever o_step is high
// or the {o_led, o_mode} pair changes.
// ---------------------------------------------------------------------------
module tb_led_sequencer;

    typedef struct packed {
        logic [3:0] led;
        logic [1:0] mode;
        logic       step;
    } exp_t;

    logic       clock;
    logic       i_reset;
    logic       i_valid;
    logic [3:0] i_btn;
    logic [3:0] o_led;
    logic [1:0] o_mode;
    logic       o_step;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    led_sequencer #(.NB_LEDS(4), .NB_BTN(4)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_btn   (i_btn),
        .o_led   (o_led),
        .o_mode  (o_mode),
        .o_step  (o_step)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- monitor ----------------
    logic [5:0] prev_out = 6'bx;

    always @(negedge clock) begin
        exp_t e;
        if (o_step === 1'b1 || {o_led, o_mode} !== prev_out) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event got led=%b mode=%0d step=%b, none expected",
                         o_led, o_mode, o_step);
            end else begin
                e = exp_q.pop_front();
                if (o_led !== e.led || o_mode !== e.mode || o_step !== e.step) begin
                    bad++;
                    $display("FAIL event got led=%b mode=%0d step=%b, want led=%b mode=%0d step=%b",
                             o_led, o_mode, o_step, e.led, e.mode, e.step);
                end else begin
                    $display("event ok led=%b mode=%0d step=%b", o_led, o_mode, o_step);
                end
            end
        end
        prev_out = {o_led, o_mode};
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_out(input logic [3:0] led, input logic [1:0] mode, input logic step);
        exp_t e;
        e.led  = led;
        e.mode = mode;
        e.step = step;
        exp_q.push_back(e);
    endtask

    task automatic tick(input logic [3:0] led, input logic [1:0] mode);
        expect_out(led, mode, 1'b1);
        @(negedge clock);
        i_valid = 1'b1;
        @(negedge clock);
        i_valid = 1'b0;
    endtask

    task automatic press(input logic [3:0] btn, input logic [3:0] led, input logic [1:0] mode);
        expect_out(led, mode, 1'b0);
        @(negedge clock);
        i_btn = btn;
        @(negedge clock);
        i_btn = 4'b0000;
    endtask

    logic [3:0] rot_seq[5]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] pong_seq[8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                4'b0010, 4'b0001, 4'b0010, 4'b0100};

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_btn   = 4'b0000;
        expect_out(4'b0001, 2'd0, 1'b0);      // reset state
        repeat (3) @(negedge clock);
        i_reset = 1'b0;

        // ROT_L, five single-cycle ticks
        for (int i = 0; i < 5; i++) tick(rot_seq[i], 2'd0);

        // held i_valid: exactly one advance
        expect_out(4'b0100, 2'd0, 1'b1);
        @(negedge clock);
        i_valid = 1'b1;
        repeat (10) @(negedge clock);
        i_valid = 1'b0;
        @(negedge clock);

        // PONG bounce
        press(4'b1000, 4'b0001, 2'd3);
        for (int i = 0; i < 8; i++) tick(pong_seq[i], 2'd3);

        // btn[1] and btn[2] rise together with a tick: ROT_R wins, tick dropped
        expect_out(4'b1000, 2'd1, 1'b0);
        @(negedge clock);
        i_valid = 1'b1;
        i_btn   = 4'b0110;
        @(negedge clock);
        i_valid = 1'b0;
        i_btn   = 4'b0000;
        tick(4'b0100, 2'd1);

        // FLASH toggling
        press(4'b0100, 4'b1111, 2'd2);
        tick(4'b0000, 2'd2);
        tick(4'b1111, 2'd2);
        tick(4'b0000, 2'd2);
        // re-requesting FLASH reloads the all-ones seed
        press(4'b0100, 4'b1111, 2'd2);

        // PONG to 0100 heading right, then reset with btn[2] held
        press(4'b1000, 4'b0001, 2'd3);
        tick(4'b0010, 2'd3);
        tick(4'b0100, 2'd3);
        tick(4'b1000, 2'd3);
        tick(4'b0100, 2'd3);
        expect_out(4'b0001, 2'd0, 1'b0);
        @(negedge clock);
        i_reset = 1'b1;
        i_btn   = 4'b0100;
        repeat (2) @(negedge clock);
        expect_out(4'b1111, 2'd2, 1'b0);
        i_reset = 1'b0;
        repeat (3) @(negedge clock);
        i_btn = 4'b0000;

        // settle, then every expected event must have been consumed
        repeat (6) @(negedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events got %0d left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop in case stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL timeout got no finish, want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
